// File: rtl/cook_timer.sv
// Microwave cook-time controller: BCD MM:SS keypad entry, 1 Hz countdown, door pause, stop/clear.
// Optional QUICK_START_EN: start at 00:00 in IDLE loads 00:30 and begins cooking.
module cook_timer #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [1:0] state,
    output logic       magnetron_on,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        cur, nxt;
    logic [PW-1:0] presc, presc_nx;
    logic [3:0]    mt, mo, st, so;
    logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
    logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
    logic          done_nx;
    logic          start_d;
    logic          start_edge, time_zero, dec_zero, key_ok, tick;

    assign start_edge = start & ~start_d;
    assign time_zero  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
    assign key_ok     = key_valid && (key_digit <= 4'd9);
    assign tick       = (presc == PRESC_LAST);

    // BCD borrow chain; secs_tens is not normalised, so 6-9 just count down.
    always_comb begin
        mt_dec = mt;
        mo_dec = mo;
        st_dec = st;
        so_dec = so;
        if (so != 4'd0) begin
            so_dec = so - 4'd1;
        end else begin
            so_dec = 4'd9;
            if (st != 4'd0) begin
                st_dec = st - 4'd1;
            end else begin
                st_dec = 4'd5;
                if (mo != 4'd0) begin
                    mo_dec = mo - 4'd1;
                end else begin
                    mo_dec = 4'd9;
                    mt_dec = mt - 4'd1;
                end
            end
        end
    end

    assign dec_zero = (mt_dec == 4'd0) && (mo_dec == 4'd0) && (st_dec == 4'd0) && (so_dec == 4'd0);

    always_comb begin
        nxt      = cur;
        presc_nx = presc;
        mt_nx    = mt;
        mo_nx    = mo;
        st_nx    = st;
        so_nx    = so;
        done_nx  = 1'b0;
        case (cur)
            S_IDLE: begin
                if (stop_clear) begin
                    mt_nx = 4'd0;
                    mo_nx = 4'd0;
                    st_nx = 4'd0;
                    so_nx = 4'd0;
                end else if (start_edge && door_closed && !time_zero) begin
                    nxt      = S_COOK;
                    presc_nx = '0;
`ifdef QUICK_START_EN
                end else if (start_edge && door_closed) begin
                    nxt      = S_COOK;
                    presc_nx = '0;
                    st_nx    = 4'd3;
                    so_nx    = 4'd0;
`endif
                end else if (key_ok) begin
                    mt_nx = mo;
                    mo_nx = st;
                    st_nx = so;
                    so_nx = key_digit;
                end
            end
            S_COOK: begin
                if (!door_closed || stop_clear) begin
                    nxt = S_PAUSE;
                end else if (tick) begin
                    presc_nx = '0;
                    mt_nx    = mt_dec;
                    mo_nx    = mo_dec;
                    st_nx    = st_dec;
                    so_nx    = so_dec;
                    if (dec_zero) begin
                        nxt     = S_DONE;
                        done_nx = 1'b1;
                    end
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop_clear) begin
                    nxt   = S_IDLE;
                    mt_nx = 4'd0;
                    mo_nx = 4'd0;
                    st_nx = 4'd0;
                    so_nx = 4'd0;
                end else if (start_edge && door_closed) begin
                    nxt      = S_COOK;
                    presc_nx = '0;
                end
            end
            S_DONE: begin
                if (stop_clear || !door_closed) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // start_d tracks start even in reset, so a level held through reset release is not an edge.
    always_ff @(posedge clk) begin
        start_d <= start;
        if (reset) begin
            cur   <= S_IDLE;
            presc <= '0;
            mt    <= 4'd0;
            mo    <= 4'd0;
            st    <= 4'd0;
            so    <= 4'd0;
            done  <= 1'b0;
        end else begin
            cur   <= nxt;
            presc <= presc_nx;
            mt    <= mt_nx;
            mo    <= mo_nx;
            st    <= st_nx;
            so    <= so_nx;
            done  <= done_nx;
        end
    end

    assign mins_tens    = mt;
    assign mins_ones    = mo;
    assign secs_tens    = st;
    assign secs_ones    = so;
    assign state        = cur;
    assign magnetron_on = (cur == S_COOK);

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed test-plan scenarios plus random stimulus vs a behavioural model.
module tb_cook_timer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, start, stop_clear, door_closed, key_valid;
    logic [3:0] key_digit;
    logic [3:0] mins_tens, mins_ones, secs_tens, secs_ones;
    logic [1:0] state;
    logic       magnetron_on, done;

    int n_cmp = 0;
    int n_err = 0;

    // model: minutes field and seconds field as plain integers 0..99
    int m_state, m_min, m_sec, m_pre, m_prev;
    bit m_done;

    cook_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .stop_clear(stop_clear),
        .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
        .mins_tens(mins_tens), .mins_ones(mins_ones), .secs_tens(secs_tens),
        .secs_ones(secs_ones), .state(state), .magnetron_on(magnetron_on), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd4(input int mi, input int se);
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
    endfunction

    function automatic logic [15:0] disp();
        return {mins_tens, mins_ones, secs_tens, secs_ones};
    endfunction

    task automatic model_step();
        bit edge_s;
        int n;
        if (reset) begin
            m_state = 0; m_min = 0; m_sec = 0; m_pre = 0; m_done = 0;
            m_prev = int'(start);
            return;
        end
        edge_s = start && (m_prev == 0);
        m_prev = int'(start);
        m_done = 0;
        case (m_state)
            0: begin
                if (stop_clear) begin
                    m_min = 0; m_sec = 0;
                end else if (edge_s && door_closed && (m_min + m_sec) != 0) begin
                    m_state = 1; m_pre = 0;
`ifdef QUICK_START_EN
                end else if (edge_s && door_closed) begin
                    m_state = 1; m_pre = 0; m_min = 0; m_sec = 30;
`endif
                end else if (key_valid && key_digit <= 9) begin
                    n = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
                    m_min = n / 100; m_sec = n % 100;
                end
            end
            1: begin
                if (!door_closed || stop_clear) m_state = 2;
                else if (m_pre == TD - 1) begin
                    m_pre = 0;
                    if (m_sec > 0) m_sec--;
                    else begin m_sec = 59; m_min--; end
                    if (m_min == 0 && m_sec == 0) begin m_state = 3; m_done = 1; end
                end else m_pre++;
            end
            2: begin
                if (stop_clear) begin m_state = 0; m_min = 0; m_sec = 0; end
                else if (edge_s && door_closed) begin m_state = 1; m_pre = 0; end
            end
            default: if (stop_clear || !door_closed) m_state = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("digits", 32'(disp()), 32'(bcd4(m_min, m_sec)));
        chk("done", 32'(done), 32'(m_done));
        chk("magnetron", 32'(magnetron_on), 32'(m_state == 1));
    endtask

    task automatic idle_inputs();
        stop_clear = 0; key_valid = 0; key_digit = 0;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1; key_digit = d; step(); key_valid = 0;
    endtask

    task automatic press_start();
        start = 1; step(); start = 0;
    endtask

    task automatic clear_key();
        stop_clear = 1; step(); stop_clear = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1; start = 1; door_closed = 1;
        idle_inputs();
        steps(3);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_digits", 32'(disp()), 32'h0);
        chk("reset_done", 32'(done), 32'd0);
        // start held high through reset release must not start anything
        reset = 0;
        steps(3);
`ifndef QUICK_START_EN
        chk("held_start_idle", 32'(state), 32'd0);
`else
        chk("held_start_idle", 32'(state), 32'd0);
`endif
        start = 0; step();

        // 01:23 then one tick
        key(4'd1); key(4'd2); key(4'd3);
        chk("entry_0123", 32'(disp()), 32'h0123);
        press_start();
        chk("cook_state", 32'(state), 32'd1);
        chk("cook_mag", 32'(magnetron_on), 32'd1);
        steps(3);
        chk("pre_tick", 32'(disp()), 32'h0123);
        step();
        chk("tick_0122", 32'(disp()), 32'h0122);
        key(4'd7);
        chk("key_in_cook", 32'(disp()), 32'h0122);
        clear_key();
        chk("sc_cook_pause", 32'(state), 32'd2);
        clear_key();
        chk("sc_pause_idle", 32'(disp()), 32'h0000);

        // borrow across secs_tens, and non-normalised 0:90
        key(4'd1); key(4'd0); key(4'd0);
        press_start(); steps(4);
        chk("borrow_0059", 32'(disp()), 32'h0059);
        clear_key(); clear_key();
        key(4'd9); key(4'd0);
        press_start(); steps(4);
        chk("dec_0089", 32'(disp()), 32'h0089);
        clear_key(); clear_key();

        // run to DONE
        key(4'd2);
        press_start(); steps(7);
        chk("pre_done", 32'(state), 32'd1);
        step();
        chk("done_state", 32'(state), 32'd3);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_digits", 32'(disp()), 32'h0000);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_mag_off", 32'(magnetron_on), 32'd0);
        clear_key();
        chk("done_to_idle", 32'(state), 32'd0);

        // door pause and resume
        key(4'd6);
        press_start(); steps(4);
        chk("at_0005", 32'(disp()), 32'h0005);
        door_closed = 0; step();
        chk("door_pause", 32'(state), 32'd2);
        steps(20);
        chk("pause_hold", 32'(disp()), 32'h0005);
        press_start();
        chk("start_door_open", 32'(state), 32'd2);
        door_closed = 1; step();
        press_start();
        chk("resume", 32'(state), 32'd1);
        steps(3);
        chk("resume_pre", 32'(disp()), 32'h0005);
        step();
        chk("resume_tick", 32'(disp()), 32'h0004);
        clear_key(); clear_key();

        // invalid digit, and start at 00:00
        key(4'd4); key(4'd12);
        chk("bad_digit", 32'(disp()), 32'h0004);
        clear_key();
        press_start();
`ifdef QUICK_START_EN
        chk("zero_start", 32'({state, disp()}), 32'h1_0030);
`else
        chk("zero_start", 32'({state, disp()}), 32'h0_0000);
`endif
        clear_key(); clear_key();

        // random phase, model checks every cycle
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(299) == 0);
            stop_clear = ($urandom_range(39) == 0);
            if ($urandom_range(24) == 0) door_closed = ~door_closed;
            if ($urandom_range(5) == 0) start = ~start;
            key_valid  = ($urandom_range(3) == 0);
            key_digit  = 4'($urandom_range(15));
            step();
        end
        reset = 0; idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
